// File: rtl/conv_pkg.sv
// Shared definitions for the convolution front end and its Gaussian/Sobel wrappers.
package conv_pkg;
  localparam int K_DEFAULT    = 3;
  localparam int NBIT_DEFAULT = 8;
  localparam int CBIT_DEFAULT = 4;

  function automatic int pbit(input int nbit, input int cbit);
    return nbit + cbit;
  endfunction

  // Window tap index; r=0 is the oldest line, c=0 the oldest column.
  function automatic int idx(input int r, input int c, input int k = K_DEFAULT);
    return r * k + c;
  endfunction

  typedef logic [K_DEFAULT*K_DEFAULT-1:0][CBIT_DEFAULT-1:0] coef_arr_t;
endpackage

// File: rtl/line_buffer.sv
// One-line pixel store: registered read, read-before-write on address collision.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/conv_window_products.sv
// Raster stream -> KSIZE x KSIZE window -> per-tap coefficient products, interior windows only.
module conv_window_products
  import conv_pkg::*;
#(
  parameter int NBIT       = 8,
  parameter int CBIT       = 4,
  parameter int KSIZE      = K_DEFAULT,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic                               in_sof,
  input  logic [NBIT-1:0]                    in_pixel,
  input  logic [KSIZE*KSIZE*CBIT-1:0]        coef,
  output logic                               out_valid,
  output logic                               out_eof,
  output logic [KSIZE*KSIZE*(NBIT+CBIT)-1:0] out_prod
);
  localparam int PBIT = pbit(NBIT, CBIT);
  localparam int NLB  = KSIZE - 1;
  localparam int NTAP = KSIZE * KSIZE;
  localparam int CW   = $clog2(IMG_WIDTH);
  localparam int RW   = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col, col_eff, col_d;
  logic [RW-1:0] row, row_eff;
  logic          sof, acc, acc_d, emit, last;
  logic [2:0]    vld_pipe, eof_pipe;
  logic [NBIT-1:0] pix_d;
  logic [NLB-1:0][NBIT-1:0] lb_rd;
  logic [KSIZE-1:0][KSIZE-1:0][NBIT-1:0] win;
  logic [NTAP-1:0][PBIT-1:0] prod_q;

  // in_sof forces (0,0) so a truncated frame never poisons the next one.
  assign sof     = in_valid & in_sof;
  assign acc     = in_valid & ~rst;
  assign col_eff = sof ? '0 : col;
  assign row_eff = sof ? '0 : row;
  assign emit    = (row_eff >= RW'(KSIZE-1)) && (col_eff >= CW'(KSIZE-1));
  assign last    = (row_eff == RW'(IMG_HEIGHT-1)) && (col_eff == CW'(IMG_WIDTH-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col_eff == CW'(IMG_WIDTH-1)) begin
        col <= '0;
        row <= (row_eff == RW'(IMG_HEIGHT-1)) ? '0 : row_eff + 1'b1;
      end else begin
        col <= col_eff + 1'b1;
        row <= row_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_d    <= 1'b0;
      vld_pipe <= '0;
      eof_pipe <= '0;
    end else begin
      acc_d    <= in_valid;
      vld_pipe <= {vld_pipe[1:0], in_valid & emit};
      eof_pipe <= {eof_pipe[1:0], in_valid & emit & last};
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      pix_d <= in_pixel;
      col_d <= col_eff;
    end
  end

  // Buffer k>0 is fed one cycle later from buffer k-1's registered read of the same column.
  for (genvar k = 0; k < NLB; k++) begin : g_lb
    if (k == 0) begin : g_head
      line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(NBIT)) u_lb (
        .clk(clk), .we(acc), .waddr(col_eff), .wdata(in_pixel),
        .re(acc), .raddr(col_eff), .rdata(lb_rd[k])
      );
    end else begin : g_tail
      line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(NBIT)) u_lb (
        .clk(clk), .we(acc_d), .waddr(col_d), .wdata(lb_rd[k-1]),
        .re(acc), .raddr(col_eff), .rdata(lb_rd[k])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (acc_d) begin
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE-1; c++)
          win[r][c] <= win[r][c+1];
      for (int r = 0; r < KSIZE-1; r++)
        win[r][KSIZE-1] <= lb_rd[KSIZE-2-r];
      win[KSIZE-1][KSIZE-1] <= pix_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
    end else if (vld_pipe[1]) begin
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++)
          prod_q[idx(r, c, KSIZE)] <= PBIT'(win[r][c]) * PBIT'(coef[idx(r, c, KSIZE)*CBIT +: CBIT]);
    end
  end

  assign out_prod  = prod_q;
  assign out_valid = vld_pipe[2];
  assign out_eof   = eof_pipe[2];
endmodule

// File: tb/tb_conv_window_products.sv
// Randomized bench: frame-image reference model with a timed expectation queue.
module tb_conv_window_products;
  localparam int K = 3, W = 8, H = 6, NB = 8, CB = 4, PB = 12, NP = K*K;
  localparam int NOUT = (H-K+1) * (W-K+1);
  localparam int RAMP_FIRST[NP] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
  localparam int RAMP_LAST[NP]  = '{29, 30, 31, 37, 38, 39, 45, 46, 47};
  localparam int GAUSS_C[NP]    = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
  localparam int GAUSS_P[NP]    = '{10, 20, 10, 20, 40, 20, 10, 20, 10};
  localparam int MAX_P[NP]      = '{3825, 3825, 3825, 3825, 3825, 3825, 3825, 3825, 3825};

  logic clk = 1'b0;
  logic rst, in_valid, in_sof;
  logic [NB-1:0] in_pixel;
  logic [NP*CB-1:0] coef;
  logic out_valid, out_eof;
  logic [NP*PB-1:0] out_prod;

  always #5 clk = ~clk;

  conv_window_products #(.NBIT(NB), .CBIT(CB), .KSIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .coef(coef), .out_valid(out_valid), .out_eof(out_eof), .out_prod(out_prod)
  );

  typedef struct {
    int               due;
    logic [NP*PB-1:0] prod;
    bit               eof;
    bit               first;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0, checks = 0, cyc = 0, phase = 0, out_cnt = 0;
  int mr = 0, mc = 0;
  int img[H][W];
  int coefv[NP];
  logic [NP*PB-1:0] last_prod = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [NP*PB-1:0] pk(input int v[NP]);
    logic [NP*PB-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) r[i*PB +: PB] = PB'(v[i]);
    return r;
  endfunction

  task automatic set_coef(input int v[NP]);
    for (int i = 0; i < NP; i++) begin
      coefv[i] = v[i];
      coef[i*CB +: CB] = CB'(v[i]);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("valid", out_valid, 1);
      chk("prod", out_prod, e.prod);
      chk("eof", out_eof, e.eof);
      if (e.first) out_cnt = 0;
      out_cnt++;
      if (e.eof) chk("frame_count", out_cnt, NOUT);
      if (phase == 1 && e.first) chk("ramp_first", out_prod, pk(RAMP_FIRST));
      if (phase == 1 && e.eof) chk("ramp_last", out_prod, pk(RAMP_LAST));
      if (phase == 2) chk("gauss", out_prod, pk(GAUSS_P));
      if (phase == 3) chk("max", out_prod, pk(MAX_P));
      last_prod = e.prod;
    end else begin
      chk("valid_idle", out_valid, 0);
      chk("eof_idle", out_eof, 0);
      chk("hold", out_prod, last_prod);
    end
  endtask

  // Model: store the pixel at its frame position and read the full window straight from the image.
  task automatic model_accept(input bit s, input int p);
    exp_t e;
    if (s) begin mr = 0; mc = 0; end
    img[mr][mc] = p;
    if (mr >= K-1 && mc >= K-1) begin
      e.due = cyc + 3;
      e.prod = '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          e.prod[(r*K+c)*PB +: PB] = PB'(img[mr-K+1+r][mc-K+1+c] * coefv[r*K+c]);
      e.eof = (mr == H-1 && mc == W-1);
      e.first = (mr == K-1 && mc == K-1);
      exp_q.push_back(e);
    end
    mc++;
    if (mc == W) begin mc = 0; mr = (mr + 1) % H; end
  endtask

  task automatic step(input bit v, input bit s, input int p, input bit r);
    @(negedge clk);
    cyc++;
    check_outputs();
    in_valid = v; in_sof = s; in_pixel = NB'(p); rst = r;
    if (r) begin
      exp_q.delete();
      mr = 0; mc = 0;
      last_prod = '0;
    end else if (v) begin
      model_accept(s, p);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'($urandom_range(1)), int'($urandom_range(255)), 0);
  endtask

  function automatic int pixval(input int mode, input int r, input int c);
    case (mode)
      0: return r*W + c;
      1: return 10;
      2: return 255;
      default: return int'($urandom_range(255));
    endcase
  endfunction

  task automatic frame(input int mode, input int gap, input bit sof0, input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        while (int'($urandom_range(99)) < gap) idle(1);
        step(1, sof0 && r == 0 && c == 0, pixval(mode, r, c), 0);
      end
  endtask

  initial begin
    int ones[NP], maxc[NP], rndc[NP];
    for (int i = 0; i < NP; i++) begin
      ones[i] = 1;
      maxc[i] = 15;
      rndc[i] = int'($urandom_range(15));
    end
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    set_coef(ones);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    idle(2);

    phase = 1; frame(0, 0, 1, -1, -1); idle(4);
    phase = 2; set_coef(GAUSS_C); frame(1, 0, 1, -1, -1); idle(4);
    phase = 3; set_coef(maxc); frame(2, 0, 1, -1, -1); idle(4);
    phase = 4; set_coef(ones); frame(0, 50, 1, -1, -1); idle(4);

    phase = 5; set_coef(rndc);
    frame(3, 0, 1, 3, 4);
    frame(3, 0, 1, -1, -1);
    idle(4);

    phase = 6;
    frame(3, 30, 1, 4, 5);
    step(1, 0, int'($urandom_range(255)), 1);
    frame(3, 0, 0, -1, -1);
    frame(3, 20, 0, -1, -1);
    idle(6);

    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
